uart_rx: RTL



---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_sync.sv | 24 ++
 rtl/uart_rx.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and default frame constants.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam int UART_D_W    = 8;
    localparam int UART_B_TICK = 16;

endpackage

// File: rtl/uart_sync.sv
// N-flop synchronizer for a single asynchronous input, with a selectable reset value.
module uart_sync #(
    parameter int   N       = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [N-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {N{RST_VAL}};
        end else begin
            r_sync <= {r_sync[N-2:0], i_d};
        end
    end

    assign o_q = r_sync[N-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled start detection, mid-bit sampling, optional parity,
// and per-frame completion strobes towards the RX FIFO and status register.
module uart_rx
    import uart_pkg::*;
#(
    parameter int D_W        = UART_D_W,
    parameter int B_TICK     = UART_B_TICK,
    parameter bit PARITY_EN  = 1'b0,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           s_tick,
    input  logic           rx_data,
    input  logic           ff_full,
    output logic           ff_wr_en,
    output logic [D_W-1:0] ff_wr_data,
    output logic           frame_err,
    output logic           parity_err,
    output logic           overrun,
    output logic           break_det,
    output logic           busy
);

    localparam int TW = $clog2(B_TICK);
    localparam int BW = $clog2(D_W);
    localparam logic [TW-1:0] T_HALF = TW'(B_TICK / 2 - 1);
    localparam logic [TW-1:0] T_LAST = TW'(B_TICK - 1);
    localparam logic [BW-1:0] B_LAST = BW'(D_W - 1);

    logic            w_rx_s;
    rx_state_t       r_state;
    logic [TW-1:0]   r_tcnt;
    logic [BW-1:0]   r_bcnt;
    logic [D_W-1:0]  r_shift;
    logic            r_par_err;
    logic            r_wr_en;
    logic [D_W-1:0]  r_wr_data;
    logic            r_frame_err;
    logic            r_parity_err;
    logic            r_overrun;
    logic            r_break_det;
    logic            r_busy;

    uart_sync #(
        .N       (2),
        .RST_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst),
        .i_d   (rx_data),
        .o_q   (w_rx_s)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_tcnt       <= '0;
            r_bcnt       <= '0;
            r_shift      <= '0;
            r_par_err    <= 1'b0;
            r_wr_en      <= 1'b0;
            r_wr_data    <= '0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_overrun    <= 1'b0;
            r_break_det  <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_wr_en      <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_overrun    <= 1'b0;
            r_break_det  <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (!w_rx_s) begin
                        r_state <= START;
                        r_tcnt  <= '0;
                        r_busy  <= 1'b1;
                    end
                end

                // Checking half a bit in re-aligns every later sample to mid-bit.
                START: begin
                    if (s_tick) begin
                        if (r_tcnt == T_HALF) begin
                            if (w_rx_s) begin
                                r_state <= IDLE;
                                r_busy  <= 1'b0;
                            end else begin
                                r_state   <= DATA;
                                r_tcnt    <= '0;
                                r_bcnt    <= '0;
                                r_par_err <= 1'b0;
                            end
                        end else begin
                            r_tcnt <= r_tcnt + TW'(1);
                        end
                    end
                end

                DATA: begin
                    if (s_tick) begin
                        if (r_tcnt == T_LAST) begin
                            r_tcnt  <= '0;
                            r_shift <= {w_rx_s, r_shift[D_W-1:1]};
                            if (r_bcnt == B_LAST) begin
                                r_state <= PARITY_EN ? PARITY : STOP;
                            end else begin
                                r_bcnt <= r_bcnt + BW'(1);
                            end
                        end else begin
                            r_tcnt <= r_tcnt + TW'(1);
                        end
                    end
                end

                PARITY: begin
                    if (s_tick) begin
                        if (r_tcnt == T_LAST) begin
                            r_tcnt    <= '0;
                            r_par_err <= ((^r_shift) ^ w_rx_s) != PARITY_ODD;
                            r_state   <= STOP;
                        end else begin
                            r_tcnt <= r_tcnt + TW'(1);
                        end
                    end
                end

                // Leaving at mid-stop lets a following start edge be seen right away.
                STOP: begin
                    if (s_tick) begin
                        if (r_tcnt == T_LAST) begin
                            r_tcnt       <= '0;
                            r_state      <= IDLE;
                            r_busy       <= 1'b0;
                            r_wr_data    <= r_shift;
                            r_parity_err <= r_par_err;
                            if (w_rx_s) begin
                                if (ff_full) begin
                                    r_overrun <= 1'b1;
                                end else begin
                                    r_wr_en <= 1'b1;
                                end
                            end else begin
                                r_frame_err <= 1'b1;
                                r_break_det <= (r_shift == '0);
                            end
                        end else begin
                            r_tcnt <= r_tcnt + TW'(1);
                        end
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign ff_wr_en   = r_wr_en;
    assign ff_wr_data = r_wr_data;
    assign frame_err  = r_frame_err;
    assign parity_err = r_parity_err;
    assign overrun    = r_overrun;
    assign break_det  = r_break_det;
    assign busy       = r_busy;

endmodule
